// File: rtl/parport_receiver.sv
// parport_receiver: strobe/ack parallel-port sink with odd-parity check and a first-word fall-through byte FIFO
module parport_receiver #(
    parameter int ACK_DELAY  = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       din,
    input  logic             strobe,
    output logic             ack,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic [7:0]       err_count,
    output logic [CNT_W-1:0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {S_RESYNC, S_IDLE, S_HOLD, S_DELAY, S_ACK} state_t;
    state_t           state_q, state_d;
    logic [8:0]       hold_q, hold_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       err_q, err_d;
    logic             perr_q, perr_d;
    logic [7:0]       mem [FIFO_DEPTH];
    logic             push, pop;
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        perr_d  = 1'b0;
        push    = 1'b0;
        pop     = (cnt_q != '0) && rx_ready;
        case (state_q)
            S_RESYNC: state_d = strobe ? S_RESYNC : S_IDLE;
            S_IDLE: begin
                if (strobe) begin
                    hold_d  = din;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // a corrupt byte is dropped but still acked so the transmitter never hangs
                if (!(^hold_q)) begin
                    perr_d  = 1'b1;
                    err_d   = err_q + {7'd0, err_q != 8'hff};
                    dcnt_d  = 4'(ACK_DELAY);
                    state_d = S_DELAY;
                end else if (cnt_q != CNT_W'(FIFO_DEPTH) || pop) begin
                    push    = 1'b1;
                    dcnt_d  = 4'(ACK_DELAY);
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                dcnt_d  = dcnt_q - 4'd1;
                state_d = (dcnt_q == 4'd1) ? S_ACK : S_DELAY;
            end
            S_ACK:   state_d = strobe ? S_ACK : S_IDLE;
            default: state_d = S_RESYNC;
        endcase
        wr_d  = wr_q + AW'(push);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESYNC;
            hold_q  <= '0;
            dcnt_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dcnt_q  <= dcnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            perr_q  <= perr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= hold_q[7:0];
    end
    assign ack        = (state_q == S_ACK);
    assign rx_valid   = (cnt_q != '0);
    assign rx_data    = rx_valid ? mem[rd_q] : 8'h00;
    assign parity_err = perr_q;
    assign err_count  = err_q;
    assign fifo_count = cnt_q;
endmodule

// File: tb/tb_parport_receiver.sv
// tb_parport_receiver: directed handshake vectors checked against a queue-based model of the receiver
module tb_parport_receiver;
    localparam int AD = 2;
    localparam int FD = 8;
    logic       clk = 0, reset = 1, strobe = 0, rx_ready = 0;
    logic [8:0] din = '0;
    logic       ack, rx_valid, parity_err;
    logic [7:0] rx_data, err_count, b;
    logic [3:0] fifo_count;
    int         vecs = 0, miss = 0, pulses = 0, p0;
    logic [7:0] q[$];
    logic [7:0] log_q[$];
    logic       m_pend = 0, m_ack = 0, m_need_low = 1, m_perr = 0, m_pop;
    logic [8:0] m_hold = '0;
    int         m_cd = 0, m_errs = 0;

    always #5 clk = ~clk;

    parport_receiver #(.ACK_DELAY(AD), .FIFO_DEPTH(FD), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .din(din), .strobe(strobe), .ack(ack),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .parity_err(parity_err), .err_count(err_count), .fifo_count(fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a capture is held until accepted, then ack follows AD edges later and lasts until strobe drops
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_pend = 0; m_cd = 0; m_ack = 0; m_need_low = 1; m_perr = 0; m_errs = 0;
        end else begin
            m_pop  = q.size() != 0 && rx_ready;
            m_perr = 0;
            if (m_ack) m_ack = strobe;
            else if (m_cd > 0) begin
                m_cd--;
                m_ack = (m_cd == 0);
            end else if (m_pend) begin
                if (^m_hold == 1'b0) begin
                    m_perr = 1;
                    m_errs = (m_errs == 255) ? 255 : m_errs + 1;
                    m_pend = 0;
                    m_cd   = AD;
                end else if (q.size() < FD || m_pop) begin
                    q.push_back(m_hold[7:0]);
                    m_pend = 0;
                    m_cd   = AD;
                end
            end else if (m_need_low) m_need_low = strobe;
            else if (strobe) begin
                m_pend = 1;
                m_hold = din;
            end
            if (m_pop) void'(q.pop_front());
        end
    end

    always @(negedge clk) begin
        chk("ack", ack, m_ack);
        chk("rx_valid", rx_valid, q.size() != 0);
        chk("rx_data", rx_data, q.size() != 0 ? q[0] : 8'h00);
        chk("fifo_count", fifo_count, q.size());
        chk("err_count", err_count, m_errs);
        chk("parity_err", parity_err, m_perr);
        if (parity_err) pulses++;
    end

    always @(posedge clk) if (!reset && rx_valid && rx_ready) log_q.push_back(rx_data);

    task automatic start(input logic [8:0] d);
        @(negedge clk);
        din = d;
        strobe = 1;
    endtask

    task automatic finish_hs();
        int n = 0;
        while (!ack && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ack) begin
            vecs++;
            miss++;
            $display("FAIL ack_timeout: ack=%0b required 1 after %0d cycles", ack, n);
        end
        strobe = 0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        chk("reset_ack", ack, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_fifo_count", fifo_count, 0);
        chk("reset_err_count", err_count, 0);
        @(negedge clk);
        reset = 0;
        // T1 good byte
        start(9'h148);
        @(negedge clk); chk("t1_no_bypass", rx_valid, 0);
        @(negedge clk); chk("t1_rx_valid", rx_valid, 1); chk("t1_rx_data", rx_data, 8'h48);
        @(negedge clk); chk("t1_ack_early", ack, 0);
        @(negedge clk); chk("t1_ack_rise", ack, 1);
        strobe = 0;
        @(negedge clk); chk("t1_ack_fall", ack, 0);
        rx_ready = 1;
        @(negedge clk); chk("t1_popped", fifo_count, 0);
        rx_ready = 0;
        // T2 bad parity
        start(9'h048);
        @(negedge clk); chk("t2_perr_pre", parity_err, 0);
        @(negedge clk); chk("t2_perr", parity_err, 1); chk("t2_err_count", err_count, 1);
        @(negedge clk); chk("t2_perr_post", parity_err, 0); chk("t2_fifo", fifo_count, 0);
        finish_hs();
        // T3 backpressure
        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            start({~^b, b});
            finish_hs();
        end
        chk("t3_full", fifo_count, 8);
        start(9'h165);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("t3_ack_held", ack, 0);
        end
        chk("t3_full_held", fifo_count, 8);
        rx_ready = 1;
        @(negedge clk);
        rx_ready = 0;
        chk("t3_push_pop", fifo_count, 8);
        chk("t3_ack_after_pop", ack, 0);
        for (int i = 1; i <= AD; i++) begin
            @(negedge clk);
            chk("t3_ack_delay", ack, i == AD);
        end
        finish_hs();
        // T4 full with concurrent pop
        start(9'h166);
        repeat (3) @(negedge clk);
        chk("t4_stalled", ack, 0);
        log_q.delete();
        rx_ready = 1;
        @(negedge clk);
        chk("t4_count_full", fifo_count, 8);
        chk("t4_head", rx_data, 8'h12);
        finish_hs();
        repeat (12) @(negedge clk);
        rx_ready = 0;
        chk("t4_drained", fifo_count, 0);
        chk("t4_pop_count", log_q.size(), 9);
        chk("t4_first", log_q.size() == 9 ? log_q[0] : 8'hxx, 8'h11);
        chk("t4_8th", log_q.size() == 9 ? log_q[7] : 8'hxx, 8'h65);
        chk("t4_last", log_q.size() == 9 ? log_q[8] : 8'hxx, 8'h66);
        // T5 reset mid-handshake
        start(9'h148);
        @(negedge clk);
        @(negedge clk);
        chk("t5_pre_count", fifo_count, 1);
        #2 reset = 1;
        #1;
        chk("t5_async_ack", ack, 0);
        chk("t5_async_count", fifo_count, 0);
        chk("t5_async_valid", rx_valid, 0);
        chk("t5_async_err", err_count, 0);
        @(negedge clk);
        reset = 0;
        repeat (5) @(negedge clk);
        chk("t5_no_capture", fifo_count, 0);
        chk("t5_no_ack", ack, 0);
        strobe = 0;
        repeat (2) @(negedge clk);
        start(9'h148);
        finish_hs();
        chk("t5_recapture", fifo_count, 1);
        // T6 error saturation
        p0 = pulses;
        for (int i = 0; i < 260; i++) begin
            b = 8'(i);
            start({^b, b});
            finish_hs();
        end
        chk("t6_err_sat", err_count, 255);
        chk("t6_pulses", pulses - p0, 260);
        chk("t6_no_push", fifo_count, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
